// File: rtl/pwm_breath_ctrl.sv
// Breathing-duty setpoint generator for perip_PWM: ramps duty up, holds, down, holds.
// Optional PWM_BREATH_ONESHOT_EN: stop in IDLE after one full cycle until ENABLE re-toggles.
module pwm_breath_ctrl #(
  parameter int CNT_W      = 32,
  parameter int PERIOD_DEF = 10000,
  parameter int STEP_DEF   = 100,
  parameter int HOLD_DEF   = 50
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CNT_W-1:0] CFG_PERIOD,
  input  logic [CNT_W-1:0] CFG_STEP,
  input  logic [15:0]      CFG_HOLD,
  output logic [CNT_W-1:0] FREQ_Cnt_Set,
  output logic [CNT_W-1:0] Chn_duty_Set,
  output logic             PERIOD_TICK,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_HH   = 3'd2,
    S_DN   = 3'd3,
    S_HL   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [15:0]        hold_q, hold_d;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        hcnt_q, hcnt_d;
  logic               tick_q, tick_d;
  logic               armed;

  logic               cfg_xfer;
  logic [CNT_W:0]     sum;
  logic signed [CNT_W:0] diff;
  logic [15:0]        hold_eff;
  logic [16:0]        hcnt_inc;
  logic               hold_done;

  assign cfg_xfer  = CFG_VALID && (state_q == S_IDLE);
  assign sum       = {1'b0, duty_q} + {1'b0, step_q};
  assign diff      = $signed({1'b0, duty_q}) - $signed({1'b0, step_q});
  assign hold_eff  = (hold_q == 16'd0) ? 16'd1 : hold_q;
  assign hcnt_inc  = {1'b0, hcnt_q} + 17'd1;
  assign hold_done = hcnt_inc >= {1'b0, hold_eff};

`ifdef PWM_BREATH_ONESHOT_EN
  // Cleared when a one-shot cycle finishes; re-armed by ENABLE going low.
  logic armed_q, armed_d;
  assign armed = armed_q;

  always_comb begin
    armed_d = armed_q;
    if (!ENABLE)
      armed_d = 1'b1;
    else if (state_q == S_HL && tick_q && hold_done)
      armed_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) armed_q <= 1'b1;
    else     armed_q <= armed_d;
  end
`else
  assign armed = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      period_q <= CNT_W'(PERIOD_DEF);
      step_q   <= CNT_W'(STEP_DEF);
      hold_q   <= 16'(HOLD_DEF);
      duty_q   <= '0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    step_d   = step_q;
    hold_d   = hold_q;
    duty_d   = duty_q;
    hcnt_d   = hcnt_q;
    if (cfg_xfer) begin
      period_d = (CFG_PERIOD < CNT_W'(2)) ? CNT_W'(2) : CFG_PERIOD;
      step_d   = (CFG_STEP == '0) ? CNT_W'(1) : CFG_STEP;
      hold_d   = CFG_HOLD;
    end
    if (state_q != S_IDLE && !ENABLE) begin
      state_d = S_IDLE;
      duty_d  = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (ENABLE && armed) state_d = S_UP;
        S_UP: if (tick_q) begin
          if (sum >= {1'b0, period_q}) begin
            duty_d  = period_q;
            hcnt_d  = '0;
            state_d = S_HH;
          end else begin
            duty_d = sum[CNT_W-1:0];
          end
        end
        S_HH: if (tick_q) begin
          hcnt_d = hcnt_inc[15:0];
          if (hold_done) state_d = S_DN;
        end
        S_DN: if (tick_q) begin
          if (diff[CNT_W] || diff == '0) begin
            duty_d  = '0;
            hcnt_d  = '0;
            state_d = S_HL;
          end else begin
            duty_d = diff[CNT_W-1:0];
          end
        end
        S_HL: if (tick_q) begin
          hcnt_d = hcnt_inc[15:0];
          if (hold_done) begin
`ifdef PWM_BREATH_ONESHOT_EN
            hcnt_d  = '0;
            state_d = S_IDLE;
`else
            state_d = S_UP;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counter mirrors the PWM counter; tick is registered from next-state values.
  always_comb begin
    cnt_d = '0;
    if (state_q != S_IDLE && state_d != S_IDLE)
      cnt_d = tick_q ? '0 : cnt_q + CNT_W'(1);
    tick_d = (state_d != S_IDLE) && (cnt_d == period_d - CNT_W'(1));
  end

  always_comb begin
    CFG_READY    = (state_q == S_IDLE);
    STATE        = state_q;
    FREQ_Cnt_Set = period_q;
    Chn_duty_Set = duty_q;
    PERIOD_TICK  = tick_q;
  end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Directed bench for pwm_breath_ctrl with a duty scoreboard popped on each period tick.
// Covers reset, breathing sequence, clamps, saturation, handshake, abort, and one-shot when defined.
module tb_pwm_breath_ctrl;
  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ENABLE = 1'b0;
  logic          CFG_VALID = 1'b0;
  logic          CFG_READY;
  logic [W-1:0]  CFG_PERIOD = '0;
  logic [W-1:0]  CFG_STEP = '0;
  logic [15:0]   CFG_HOLD = '0;
  logic [W-1:0]  FREQ_Cnt_Set;
  logic [W-1:0]  Chn_duty_Set;
  logic          PERIOD_TICK;
  logic [2:0]    STATE;

  pwm_breath_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .ENABLE       (ENABLE),
    .CFG_VALID    (CFG_VALID),
    .CFG_READY    (CFG_READY),
    .CFG_PERIOD   (CFG_PERIOD),
    .CFG_STEP     (CFG_STEP),
    .CFG_HOLD     (CFG_HOLD),
    .FREQ_Cnt_Set (FREQ_Cnt_Set),
    .Chn_duty_Set (Chn_duty_Set),
    .PERIOD_TICK  (PERIOD_TICK),
    .STATE        (STATE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;
  logic [31:0] dq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input int p, input int s, input int h);
    CFG_VALID  = 1'b1;
    CFG_PERIOD = W'(p);
    CFG_STEP   = W'(s);
    CFG_HOLD   = 16'(h);
    step();
    CFG_VALID  = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!PERIOD_TICK && n < 25);
  endtask

  // Each tick: check spacing, then pop the expected duty of the ending period.
  task automatic run(input int first, input int per, input int cnt);
    int n;
    logic [31:0] e;
    for (int i = 0; i < cnt; i++) begin
      wait_tick(n);
      chk("tick_gap", 32'(n), 32'((i == 0) ? first : per));
      e = (dq.size() > 0) ? dq.pop_front() : 32'hFFFF_FFFF;
      chk("duty", Chn_duty_Set, e);
    end
  endtask

  initial begin
    int tc;
    #12;
    RST = 1'b0;
    chk("rst_freq", FREQ_Cnt_Set, 32'd10000);
    chk("rst_duty", Chn_duty_Set, 32'd0);
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_ready", 32'(CFG_READY), 32'd1);
    chk("rst_tick", 32'(PERIOD_TICK), 32'd0);

    // Breathing 10/3/2
    cfg(10, 3, 2);
    chk("cfg_freq", FREQ_Cnt_Set, 32'd10);
    foreach (dq[i]) dq.delete(i);
    dq = '{0, 3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 0};
`ifndef PWM_BREATH_ONESHOT_EN
    dq.push_back(0);
    dq.push_back(3);
`endif
    ENABLE = 1'b1;
    step();
    chk("en_state", 32'(STATE), 32'd1);
`ifdef PWM_BREATH_ONESHOT_EN
    run(9, 10, 12);
    step();
    chk("os_state", 32'(STATE), 32'd0);
    chk("os_duty", Chn_duty_Set, 32'd0);
    repeat (15) step();
    chk("os_hold", 32'(STATE), 32'd0);
    ENABLE = 1'b0;
    step();
    ENABLE = 1'b1;
    step();
    chk("os_retrig", 32'(STATE), 32'd1);
`else
    run(9, 10, 14);
`endif

    // Handshake ignored outside IDLE
    CFG_VALID  = 1'b1;
    CFG_PERIOD = 32'd20;
    CFG_STEP   = 32'd3;
    CFG_HOLD   = 16'd2;
    chk("hs_ready", 32'(CFG_READY), 32'd0);
    step();
    chk("hs_freq_run", FREQ_Cnt_Set, 32'd10);
    ENABLE = 1'b0;
    step();
    chk("hs_idle", 32'(STATE), 32'd0);
    chk("hs_freq_keep", FREQ_Cnt_Set, 32'd10);
    chk("hs_ready_idle", 32'(CFG_READY), 32'd1);
    step();
    CFG_VALID = 1'b0;
    chk("hs_freq_new", FREQ_Cnt_Set, 32'd20);

    // Abort in DOWN at counter 4 with duty 7
    cfg(10, 3, 2);
    dq = '{0, 3, 6, 9, 10, 10, 10};
    ENABLE = 1'b1;
    step();
    run(9, 10, 7);
    repeat (5) step();
    chk("ab_duty_pre", Chn_duty_Set, 32'd7);
    chk("ab_state_pre", 32'(STATE), 32'd3);
    ENABLE = 1'b0;
    step();
    chk("ab_duty", Chn_duty_Set, 32'd0);
    chk("ab_state", 32'(STATE), 32'd0);
    tc = 0;
    repeat (20) begin
      step();
      if (PERIOD_TICK) tc++;
    end
    chk("ab_no_tick", 32'(tc), 32'd0);

    // Clamps: period 0 -> 2, step 0 -> 1, hold 0 -> 1
    cfg(0, 0, 0);
    chk("cl_freq", FREQ_Cnt_Set, 32'd2);
    dq = '{0, 1, 2, 2, 1, 0};
    ENABLE = 1'b1;
    step();
    run(1, 2, 6);
    ENABLE = 1'b0;
    step();

    // Saturation: period 5, step 7
    cfg(5, 7, 1);
    chk("sat_freq", FREQ_Cnt_Set, 32'd5);
    dq = '{0, 5, 5, 0};
    ENABLE = 1'b1;
    step();
    run(4, 5, 4);
    chk("sb_drained", 32'(dq.size()), 32'd0);
    step();

    // Asynchronous reset without a clock edge
    #2;
    RST = 1'b1;
    #1;
    chk("arst_freq", FREQ_Cnt_Set, 32'd10000);
    chk("arst_duty", Chn_duty_Set, 32'd0);
    chk("arst_state", 32'(STATE), 32'd0);
    chk("arst_ready", 32'(CFG_READY), 32'd1);
    chk("arst_tick", 32'(PERIOD_TICK), 32'd0);
    ENABLE = 1'b0;
    #2;
    RST = 1'b0;
    step();
    chk("post_rst_state", 32'(STATE), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pwm_breath_ctrl.md
Name: pwm_breath_ctrl

Overview:
Upstream setpoint generator for perip_PWM. It drives perip_PWM's FREQ_Cnt_Set and Chn_duty_Set so that a single PWM channel "breathes": the duty ramps up, holds, ramps down and holds again. Duty changes only on PWM period boundaries. An internal period counter mirrors the PWM counter, so no glitched duty cycle ever reaches the output.

Parameters:
CNT_W, 32, width of the period and duty values
PERIOD_DEF, 10000, period (clock cycles) loaded on reset
STEP_DEF, 100, duty increment or decrement per period, loaded on reset
HOLD_DEF, 50, number of periods held at each extreme, loaded on reset

Ports:
CLK  in  1  system clock, all logic on the rising edge
RST  in  1  asynchronous, active-high reset
ENABLE  in  1  1 = run the breathing sequence, 0 = force IDLE
CFG_VALID  in  1  configuration request
CFG_READY  out  1  configuration can be accepted (high only in IDLE)
CFG_PERIOD  in  CNT_W  new PWM period
CFG_STEP  in  CNT_W  new duty step
CFG_HOLD  in  16  new hold length, in periods
FREQ_Cnt_Set  out  CNT_W  period to perip_PWM (registered)
Chn_duty_Set  out  CNT_W  duty to perip_PWM (registered)
PERIOD_TICK  out  1  one-cycle pulse on the last cycle of each period
STATE  out  3  current state encoding, for debug

Behaviour:
- Reset values:
  - FREQ_Cnt_Set = PERIOD_DEF, step register = STEP_DEF, hold register = HOLD_DEF.
  - Chn_duty_Set = 0, PERIOD_TICK = 0, STATE = IDLE(0), CFG_READY = 1.
  - Period counter = 0, hold counter = 0.
- Period counter:
  - Runs only when STATE != IDLE; held at 0 in IDLE.
  - Counts 0..FREQ_Cnt_Set-1, then wraps to 0.
  - PERIOD_TICK is registered: it is 1 in the cycle where the counter equals FREQ_Cnt_Set-1.
- Config handshake:
  - A transfer occurs when CFG_VALID & CFG_READY at a rising edge.
  - Values are latched with clamping: period < 2 becomes 2; step = 0 becomes 1.
  - FREQ_Cnt_Set updates in the cycle after the transfer.
  - CFG_VALID while not in IDLE is ignored. No ack is given and no value changes.
- States: IDLE(0), UP(1), HOLD_HI(2), DOWN(3), HOLD_LO(4).
  - IDLE, ENABLE=1: go to UP next cycle; the counter starts at 0. If a config transfer happens in the same cycle, the new values are used.
  - UP, on tick: duty = min(duty+step, period). If the result equals period, go to HOLD_HI and clear the hold counter.
  - HOLD_HI, on tick: hold counter +1. When the counter reaches max(hold,1), go to DOWN.
  - DOWN, on tick: duty = max(duty-step, 0), computed in signed CNT_W+1 bits. If the result is 0, go to HOLD_LO and clear the hold counter.
  - HOLD_LO, on tick: same hold rule as HOLD_HI, then go to UP.
- Duty arithmetic uses CNT_W+1 bits internally, so duty+step never wraps.
- Duty register latency: Chn_duty_Set changes in the cycle after PERIOD_TICK=1.
- ENABLE=0 in any non-IDLE state, including mid-period: next cycle STATE=IDLE, Chn_duty_Set=0, counters=0. FREQ_Cnt_Set is retained.
- RST asserted mid-operation: all registers return to reset values immediately, with no clock needed.
- Out of IDLE the config is frozen, so period and duty are never inconsistent.

Optional Feature:
PWM_BREATH_ONESHOT_EN
- Defined: when the HOLD_LO hold completes, go to IDLE (duty 0, CFG_READY=1) instead of UP. A new cycle requires ENABLE to be low for at least one cycle and then high again; an ENABLE level held high does not retrigger.
- Undefined: HOLD_LO loops back to UP forever while ENABLE=1.

Test Plan:
- Reset: assert RST mid-run → FREQ_Cnt_Set=10000, Chn_duty_Set=0, STATE=0, CFG_READY=1, checked asynchronously before any clock edge.
- Config, then breathe: send CFG 10/3/2, raise ENABLE → ticks every 10 cycles. Duty sequence 3,6,9,10, then 2 periods at 10, then 7,4,1,0, then 2 periods at 0, then 3 again.
- Clamps: CFG period 0 → 2; step 0 → 1; hold 0 → one-period hold; period 5 with step 7 → duty saturates at 5.
- Handshake: CFG_VALID=1 with period 20 while in UP → CFG_READY=0, FREQ_Cnt_Set unchanged. After ENABLE=0 → accepted in IDLE.
- Abort: drop ENABLE at counter=4 in DOWN with duty 7 → next cycle duty=0, STATE=0, PERIOD_TICK never asserts.
- ONESHOT (macro defined): 10/3/2 → one full cycle ends in IDLE, duty 0; a new cycle starts only after an ENABLE low-then-high toggle.
